// File: rtl/pipelined_rca_pkg.sv
// Shared defaults and mode encoding for the pipelined ripple-carry adder/subtractor.
package pipelined_rca_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SEG_DEF   = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module rca_segment
  import pipelined_rca_pkg::*;
#(
  parameter int SEG = SEG_DEF
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           msb_cin_o
);

  logic [SEG:0] c;

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < SEG; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o    = c[SEG];
  assign msb_cin_o = c[SEG-1];

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit add/subtract pipelined SEG bits per stage, with valid/ready flow control that stalls as a whole.
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG   = SEG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = WIDTH / SEG;

  if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_params
    $error("pipelined_rca: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic             is_sub;
  logic             advance;

  logic [STAGES-1:0] valid_q, valid_d, carry_q, carry_d, msb_q, msb_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];

  logic [STAGES-1:0] v_in, c_in, seg_cout, seg_msb;
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  r_in  [STAGES];
  logic [SEG-1:0]    seg_sum [STAGES];

  assign is_sub   = (mode_e'(sub) == MODE_SUB);
  assign advance  = !(valid_q[STAGES-1] && !out_ready);
  assign in_ready = rst_n && advance;

  // Subtraction is folded into stage 0: invert B and the borrow so every stage only ever adds.
  always_comb begin
    v_in[0] = in_valid;
    a_in[0] = a;
    b_in[0] = b ^ {WIDTH{is_sub}};
    c_in[0] = carry_in ^ is_sub;
    r_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = valid_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = carry_q[k-1];
      r_in[k] = res_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_segment #(.SEG(SEG)) u_seg (
      .a_i       (a_in[k][k*SEG +: SEG]),
      .b_i       (b_in[k][k*SEG +: SEG]),
      .cin_i     (c_in[k]),
      .sum_o     (seg_sum[k]),
      .cout_o    (seg_cout[k]),
      .msb_cin_o (seg_msb[k])
    );
  end

  always_comb begin
    valid_d = v_in;
    carry_d = seg_cout;
    msb_d   = seg_msb;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]                 = a_in[k];
      b_d[k]                 = b_in[k];
      res_d[k]               = r_in[k];
      res_d[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  // NOTE: these are pipeline registers, not a memory, so the data is reset too; that keeps outputs at 0 during reset.
  // NOTE: non-blocking assignments so every stage samples the previous stage's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      msb_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      msb_q   <= msb_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign carry_out = carry_q[STAGES-1];
  assign overflow  = carry_q[STAGES-1] ^ msb_q[STAGES-1];

  // The last stage has no successor for its operand skew, and only its MSB tap feeds overflow.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], msb_q};

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca (WIDTH=16, SEG=4): directed cases, back-pressured stream, random traffic, reset.
module tb_pipelined_rca;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        carry_in, sub;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        carry_out, overflow;

  pipelined_rca #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bit   hold_all   = 0;
  bit   rand_ready = 0;
  bit   win_on     = 0;
  int   win_lo     = 0;
  int   win_hi     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    exp_t m;
    int ua = ta;
    int ub = tb;
    int ci = tc;
    int sa = $signed(ta);
    int sbv = $signed(tb);
    int full, sfull;
    if (!ts) begin
      full  = ua + ub + ci;
      sfull = sa + sbv + ci;
      m.co  = (full > 65535);
    end else begin
      full  = ua - ub - ci;
      sfull = sa - sbv - ci;
      m.co  = (full >= 0);
    end
    m.res = full[15:0];
    m.ov  = (sfull > 32767) || (sfull < -32768);
    m.acc = 0;
    m.lat = 0;
    return m;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic co, input logic ov);
    exp_t m;
    m.res = r; m.co = co; m.ov = ov; m.acc = 0; m.lat = 0;
    return m;
  endfunction

  // Called at a falling edge; holds the beat until accepted and returns on a later falling edge.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                      input exp_t e, input bit lat);
    bit done = 0;
    a = ta; b = tb; carry_in = tc; sub = ts; in_valid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (in_ready) begin
        e.acc = cyc;
        e.lat = lat;
        sb.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    check("accept_timeout", 32'(done), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [15:0] ta, tb;
    logic tc, ts;
    ta = 16'($urandom); tb = 16'($urandom);
    tc = 1'($urandom); ts = 1'($urandom);
    send(ta, tb, tc, ts, model(ta, tb, tc, ts), lat);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Ready driver; also checks in_ready during the back-pressure window of the stream test.
  always @(negedge clk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else            out_ready = !(hold_all || (win_on && cyc >= win_lo && cyc <= win_hi));
    #1;
    if (win_on && rst_n)
      check("in_ready_stream", 32'(in_ready), 32'(!(cyc >= win_lo && cyc <= win_hi)));
  end

  // Monitor: pops the scoreboard on each handshake and checks hold stability and latency.
  bit          held = 0;
  bit          seen = 0;
  logic [17:0] held_val;
  exp_t        head;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      held = 0;
      seen = 0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({result, carry_out, overflow}), 32'(held_val));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          head = sb[0];
          if (!seen) begin
            seen = 1;
            if (head.lat) check("latency", 32'(cyc - head.acc), 32'd4);
          end
          if (out_ready) begin
            check("result", 32'(result), 32'(head.res));
            check("carry_out", 32'(carry_out), 32'(head.co));
            check("overflow", 32'(overflow), 32'(head.ov));
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
      held     = out_valid && !out_ready;
      held_val = {result, carry_out, overflow};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({result, carry_out, overflow}), 32'd0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, each isolated so latency is exact.
    send(16'h1234, 16'h0FFF, 1'b1, 1'b0, mk(16'h2234, 1'b0, 1'b0), 1); drain();
    send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), 1); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1), 1); drain();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0), 1); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), 1); drain();

    // Eight back-to-back beats; consumer stalls on output cycles 3..5.
    win_lo = cyc + 7;
    win_hi = cyc + 9;
    win_on = 1;
    for (int i = 0; i < 8; i++) send_rand(0);
    drain();
    win_on = 0;

    // Random traffic with bubbles and random back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 24; i++) begin
      send_rand(0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    rand_ready = 0;
    @(negedge clk);

    // Reset with three beats in flight, the oldest held at the output.
    hold_all = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_rand(0);
    for (int n = 0; n < 10; n++) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
    end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_outputs", 32'({result, carry_out, overflow}), 32'd0);
    sb.delete();
    hold_all = 0;
    repeat (2) @(negedge clk);
    a = 16'hA5A5; b = 16'h5A5A; carry_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    #3 rst_n = 1'b1;
    #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    head = model(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    head.acc = cyc;
    head.lat = 1;
    sb.push_back(head);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SEG, default 4, meaning bits resolved per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 The block SHALL have the following ports:
- clk  input  1  the single clock; all state is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result beat.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  carry from MSB; in subtract mode, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.

Function
REQ-004 Add SHALL compute {carry_out,result} = a + b + carry_in.
REQ-005 Subtract SHALL compute a + ~b + ~carry_in, i.e. a - b - carry_in.
REQ-006 overflow SHALL equal the carry into the MSB XOR carry_out.
REQ-007 Stage k SHALL resolve bits [k*SEG +: SEG] using the registered carry from stage k-1.
REQ-008 Unresolved upper operand bits SHALL be skewed forward in registers alongside the carry.
REQ-009 Latency SHALL be STAGES cycles from an accepted beat (in_valid && in_ready) to out_valid, with no stalls.
REQ-010 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-011 A per-stage valid bit SHALL travel with the data.
REQ-012 The pipeline SHALL stall as a whole when out_valid && !out_ready.
REQ-013 During a stall, in_ready SHALL be 0 and every stage register SHALL hold.
REQ-014 Otherwise in_ready SHALL be 1.
REQ-015 in_ready SHALL NOT depend combinationally on in_valid.
REQ-016 Output data SHALL remain stable while out_valid && !out_ready.
REQ-017 Beats SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-018 Empty slots (bubbles) SHALL propagate with valid=0 and SHALL NOT assert out_valid.
REQ-019 Simultaneous accept and output on the same cycle SHALL be legal.
REQ-020 WIDTH not divisible by SEG, or SEG > WIDTH, SHALL be a parameter error, reported at elaboration.

Reset
REQ-021 rst_n low SHALL immediately clear all stage valid bits, so out_valid = 0 with no clock required.
REQ-022 While rst_n is low, result, carry_out and overflow SHALL be 0.
REQ-023 While rst_n is low, in_ready SHALL be 0.
REQ-024 Beats in flight at reset SHALL be discarded.
REQ-025 The first accept after release SHALL be possible on the first clk edge with rst_n high.

Structure
REQ-026 Package pipelined_rca_pkg SHALL hold default WIDTH/SEG constants and the mode encoding (ADD=0, SUB=1).
REQ-027 One sub-module, rca_segment, SHALL be used: a combinational SEG-bit ripple adder with cin/cout and an MSB carry-in tap, instantiated once per stage.

Verification (WIDTH=16, SEG=4, latency 4)
REQ-028 a=0x1234, b=0x0FFF, sub=0, carry_in=1 -> result=0x2234, carry_out=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-029 a=0x0005, b=0x0007, sub=1, carry_in=0 -> result=0xFFFE, carry_out=0 (borrow), overflow=0.
REQ-030 a=0x7FFF, b=0x0001, sub=0, carry_in=0 -> result=0x8000, carry_out=0, overflow=1.
REQ-031 a=0xFFFF, b=0x0000, sub=0, carry_in=1 -> result=0x0000, carry_out=1, confirming the carry crosses all 4 stages.
REQ-032 Stream 8 random beats back-to-back with out_ready low on cycles 3-5 -> in_ready low on those cycles, output held stable, all 8 results correct and in order against a reference model.
REQ-033 Reset with 3 beats in flight -> out_valid drops asynchronously, no stale result appears after release, and a fresh beat completes in 4 cycles.
